// File: rtl/mem_rd_arbiter.sv
// Read-channel arbiter between dcache and icache onto a single-outstanding
// AXI-style read port; dcache has priority unless the icache has starved.
module mem_rd_arbiter #(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        dc_rd_req,
    input  logic [2:0]  dc_rd_type,
    input  logic [31:0] dc_rd_addr,
    output logic        dc_rd_rdy,
    output logic        dc_ret_valid,
    output logic        dc_ret_last,

    input  logic        ic_rd_req,
    input  logic [2:0]  ic_rd_type,
    input  logic [31:0] ic_rd_addr,
    output logic        ic_rd_rdy,
    output logic        ic_ret_valid,
    output logic        ic_ret_last,

    output logic [31:0] ret_data,

    output logic        arvalid,
    input  logic        arready,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [3:0]  arid,

    input  logic        rvalid,
    output logic        rready,
    input  logic [31:0] rdata,
    input  logic        rlast,
    input  logic [3:0]  rid
);

    localparam int unsigned    CW      = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0]  MAX_CNT = CW'(MAX_WAIT);
    localparam logic [3:0]     ID_IC   = 4'd0;
    localparam logic [3:0]     ID_DC   = 4'd1;
    localparam logic [2:0]     TYPE_LINE = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t          state_q;
    logic            arvalid_q;
    logic            rready_q;
    logic [31:0]     addr_q;
    logic [2:0]      type_q;
    logic [3:0]      id_q;
    logic            id_err_q, id_err_d;
    logic [CW-1:0]   ic_starve_cnt_q, ic_starve_cnt_d;

    logic            ic_forced;
    logic            grant_dc;
    logic            grant_ic;
    logic            beat;
    logic            is_line;

    // Grants are combinational so rdy is seen in the same IDLE cycle as the
    // request; resetn gating keeps them low while reset is held.
    always_comb begin
        ic_forced = (ic_starve_cnt_q >= MAX_CNT);
        grant_dc  = resetn && (state_q == IDLE) && dc_rd_req && !(ic_rd_req && ic_forced);
        grant_ic  = resetn && (state_q == IDLE) && ic_rd_req && !grant_dc;
        beat      = rready_q && rvalid;
    end

    always_comb begin
        ic_starve_cnt_d = ic_starve_cnt_q;
        if (!ic_rd_req || grant_ic) begin
            ic_starve_cnt_d = '0;
        end else if (ic_starve_cnt_q != MAX_CNT) begin
            ic_starve_cnt_d = ic_starve_cnt_q + CW'(1);
        end
    end

    // A mismatching rid is still delivered to the latched owner; only flagged.
    always_comb begin
        id_err_d = id_err_q | (beat && (rid != id_q));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q         <= IDLE;
            arvalid_q       <= 1'b0;
            rready_q        <= 1'b0;
            addr_q          <= '0;
            type_q          <= '0;
            id_q            <= '0;
            id_err_q        <= 1'b0;
            ic_starve_cnt_q <= '0;
        end else begin
            ic_starve_cnt_q <= ic_starve_cnt_d;
            id_err_q        <= id_err_d;
            case (state_q)
                IDLE: begin
                    if (grant_dc) begin
                        state_q   <= ADDR;
                        arvalid_q <= 1'b1;
                        addr_q    <= dc_rd_addr;
                        type_q    <= dc_rd_type;
                        id_q      <= ID_DC;
                    end else if (grant_ic) begin
                        state_q   <= ADDR;
                        arvalid_q <= 1'b1;
                        addr_q    <= ic_rd_addr;
                        type_q    <= ic_rd_type;
                        id_q      <= ID_IC;
                    end
                end
                ADDR: begin
                    if (arready) begin
                        state_q   <= DATA;
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                    end
                end
                DATA: begin
                    if (rvalid && rlast) begin
                        state_q  <= IDLE;
                        rready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b0;
                end
            endcase
        end
    end

    // Address-channel fields come straight from the latched request, so they
    // cannot move while the handshake is stalled.
    always_comb begin
        is_line = (type_q == TYPE_LINE);
        arvalid = arvalid_q;
        araddr  = is_line ? {addr_q[31:4], 4'b0000} : addr_q;
        arlen   = is_line ? 8'd3 : 8'd0;
        arsize  = is_line ? 3'd2 : {1'b0, type_q[1:0]};
        arid    = id_q;
        rready  = rready_q;
    end

    always_comb begin
        dc_rd_rdy    = grant_dc;
        ic_rd_rdy    = grant_ic;
        dc_ret_valid = beat && (id_q == ID_DC);
        ic_ret_valid = beat && (id_q != ID_DC);
        dc_ret_last  = dc_ret_valid && rlast;
        ic_ret_last  = ic_ret_valid && rlast;
        ret_data     = beat ? rdata : 32'd0;
    end

    a_one_owner: assert property (@(posedge clk) disable iff (!resetn)
        !(dc_ret_valid && ic_ret_valid));

    a_ar_stable: assert property (@(posedge clk) disable iff (!resetn)
        (arvalid && !arready) |=> (arvalid && $stable(araddr) && $stable(arlen)
                                   && $stable(arsize) && $stable(arid)));

endmodule
